fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage RV32 core. It owns the program counter, issues requests to instruction memory, and loads the IF/ID pipeline register whose instruction field drives the decode controller. It applies branch/jump redirects from execute and trap/mret redirects from the CSR unit, kills wrong-path fetches, and honours decode stalls from the hazard unit.

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: the canonical NOP
// that fills IF/ID bubbles and the fetch FSM state encoding.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A bubble replaces the instruction with a NOP and
// clears valid but keeps the last PC; a load captures a real instruction.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             bubble_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;
  logic             valid_q;

  // Bubble wins over load so a redirect can never let a wrong-path word through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= WIDTH'(NOP_INSTR);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      instr_q <= WIDTH'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, imem request, redirect handling
// and the drain of a stale outstanding fetch after a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             epc_taken,
  input  logic [WIDTH-1:0] epc_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_valid,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic             valid_d
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_f_q, pc_f_d;
  logic [WIDTH-1:0] pc_pend_q, pc_pend_d;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             ifid_load;
  logic             ifid_bubble;

  assign redirect = epc_taken | br_taken;
  assign target   = (epc_taken ? epc_target : br_target) & ~WIDTH'(3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_f_q    <= RESET_PC;
      pc_pend_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_pend_q <= pc_pend_d;
    end
  end

  // A redirect with no response yet must wait out the stale request in DRAIN,
  // because imem cannot be retargeted while that request is outstanding.
  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    pc_pend_d   = pc_pend_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          ifid_bubble = 1'b1;
          pc_pend_d   = target;
          if (imem_valid) begin
            pc_f_d = target;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_valid) begin
          if (!stall) begin
            ifid_load = 1'b1;
            pc_f_d    = pc_f_q + WIDTH'(4);
          end
        end else if (!stall) begin
          ifid_bubble = 1'b1;
        end
      end
      DRAIN: begin
        ifid_bubble = 1'b1;
        if (redirect) begin
          pc_pend_d = target;
        end
        if (imem_valid) begin
          pc_f_d  = redirect ? target : pc_pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req  = reset;
  assign imem_addr = pc_f_q;

  if_id_reg #(
    .WIDTH(WIDTH)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .bubble_i(ifid_bubble),
    .instr_i (imem_rdata),
    .pc_i    (pc_f_q),
    .instr_o (instr_d),
    .pc_o    (pc_d),
    .valid_o (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a configurable-latency imem model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brT;
    logic        epc;
    logic [31:0] epcT;
    logic [31:0] expAddr;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expValid;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        epc_taken = 1'b0;
  logic [31:0] epc_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;

  int total = 0;
  int bad = 0;
  int lat = 1;
  logic [31:0] lastAddr;
  int waitCnt;
  logic sawPc8 = 1'b0;
  logic watchPc8 = 1'b0;
  vec_t vecs[15];

  always #5 clk = ~clk;

  fetch_stage #(
    .WIDTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .epc_taken (epc_taken),
    .epc_target(epc_target),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .valid_d   (valid_d)
  );

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // imem answers in the lat-th cycle an address has been presented, then holds.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastAddr <= 32'hFFFF_FFFF;
      waitCnt  <= 0;
    end else if (imem_req) begin
      waitCnt  <= (imem_addr == lastAddr) ? waitCnt + 1 : 1;
      lastAddr <= imem_addr;
    end
  end

  assign imem_rdata = instrOf(imem_addr);
  assign imem_valid = imem_req && (((imem_addr == lastAddr) ? waitCnt : 0) >= lat - 1);

  always @(posedge clk) begin
    #1;
    if (watchPc8 && valid_d && pc_d == 32'h8) sawPc8 <= 1'b1;
  end

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                              input logic e, input logic [31:0] et, input logic [31:0] a,
                              input logic [31:0] ins, input logic [31:0] p, input logic v);
    vec_t r;
    r.stall = s; r.br = b; r.brT = bt; r.epc = e; r.epcT = et;
    r.expAddr = a; r.expInstr = ins; r.expPc = p; r.expValid = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check the request before the edge and IF/ID after it.
  task automatic applyStimulus(input vec_t v, input string tag);
    stall = v.stall; br_taken = v.br; br_target = v.brT;
    epc_taken = v.epc; epc_target = v.epcT;
    #1;
    checkOutput({tag, " req"}, {31'b0, imem_req}, 32'h1);
    checkOutput({tag, " addr"}, imem_addr, v.expAddr);
    @(posedge clk);
    #1;
    checkOutput({tag, " instr"}, instr_d, v.expInstr);
    checkOutput({tag, " pc"}, pc_d, v.expPc);
    checkOutput({tag, " valid"}, {31'b0, valid_d}, {31'b0, v.expValid});
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " req"}, {31'b0, imem_req}, 32'h0);
    checkOutput({tag, " instr"}, instr_d, NOP);
    checkOutput({tag, " pc"}, pc_d, 32'h0);
    checkOutput({tag, " valid"}, {31'b0, valid_d}, 32'h0);
    checkOutput({tag, " addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 32'h0, instrOf(32'h0), 32'h0, 1);
    vecs[1]  = mk(0, 0, 0, 0, 0, 32'h4, instrOf(32'h4), 32'h4, 1);
    vecs[2]  = mk(1, 0, 0, 0, 0, 32'h8, instrOf(32'h4), 32'h4, 1);
    vecs[3]  = mk(1, 0, 0, 0, 0, 32'h8, instrOf(32'h4), 32'h4, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 32'h8, instrOf(32'h8), 32'h8, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'hC, instrOf(32'hC), 32'hC, 1);
    vecs[6]  = mk(0, 1, 32'h102, 0, 0, 32'h10, NOP, 32'hC, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 32'h100, instrOf(32'h100), 32'h100, 1);
    vecs[8]  = mk(1, 1, 32'h300, 1, 32'h200, 32'h104, NOP, 32'h100, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 32'h200, instrOf(32'h200), 32'h200, 1);
    vecs[10] = mk(1, 1, 32'hFFFF_FFFE, 0, 0, 32'h204, NOP, 32'h200, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 32'hFFFF_FFFC, instrOf(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 32'h0, instrOf(32'h0), 32'h0, 1);
    vecs[13] = mk(0, 0, 0, 1, 32'h203, 32'h4, NOP, 32'h0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 32'h200, instrOf(32'h200), 32'h200, 1);

    lat = 1;
    #12;
    checkResetState("reset0");
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], $sformatf("zw%0d", i));

    @(posedge clk);
    #1 reset = 1'b0;
    lat = 3;
    @(posedge clk);
    #1 reset = 1'b1;
    watchPc8 = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0), "l3c0");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0), "l3c1");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, instrOf(32'h0), 32'h0, 1), "l3c2");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h4, NOP, 32'h0, 0), "l3c3");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h4, NOP, 32'h0, 0), "l3c4");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h4, instrOf(32'h4), 32'h4, 1), "l3c5");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h8, NOP, 32'h4, 0), "l3c6");
    applyStimulus(mk(0, 1, 32'h40, 0, 0, 32'h8, NOP, 32'h4, 0), "l3c7");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h8, NOP, 32'h4, 0), "l3c8");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h40, NOP, 32'h4, 0), "l3c9");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h40, NOP, 32'h4, 0), "l3c10");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h40, instrOf(32'h40), 32'h40, 1), "l3c11");
    applyStimulus(mk(0, 1, 32'h80, 0, 0, 32'h44, NOP, 32'h40, 0), "l3c12");
    applyStimulus(mk(0, 1, 32'h80, 1, 32'hC0, 32'h44, NOP, 32'h40, 0), "l3c13");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h44, NOP, 32'h40, 0), "l3c14");
    applyStimulus(mk(0, 1, 32'h100, 0, 0, 32'hC0, NOP, 32'h40, 0), "l3c15");
    watchPc8 = 1'b0;
    checkOutput("never pc8", {31'b0, sawPc8}, 32'h0);

    // Reset lands while the stale request to 0xC0 is still draining.
    stall = 0; br_taken = 0; epc_taken = 0;
    #2 reset = 1'b0;
    #1;
    checkResetState("reset_drain");
    @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0), "post0");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, NOP, 32'h0, 0), "post1");
    applyStimulus(mk(0, 0, 0, 0, 0, 32'h0, instrOf(32'h0), 32'h0, 1), "post2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
